// File: rtl/tdc_reader_pkg.sv
// Shared types and constants for the TDC record reader: FSM encoding,
// record geometry and the bit layout of word 0 of each channel record.
package tdc_reader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_HI,
      S_WAIT_HI,
      S_RD_LO,
      S_WAIT_LO,
      S_PRESENT,
      S_DONE
   } state_t;

   localparam int N_CHANNELS       = 4;
   localparam int WORDS_PER_RECORD = 2;

   localparam int EVENT_W   = 8;
   localparam int CHANNEL_W = 2;
   localparam int DOUT_W    = 7;
   localparam int SAFF_W    = 21;

   // word0 = {DOUT[6:0], pad[3:0], SAFF[20:16]}; word1 = SAFF[15:0]
   localparam int DOUT_MSB    = 15;
   localparam int DOUT_LSB    = 9;
   localparam int PAD_MSB     = 8;
   localparam int PAD_LSB     = 5;
   localparam int SAFF_HI_MSB = 4;
   localparam int SAFF_HI_LSB = 0;

endpackage

// File: rtl/tdc_record_reader_if.sv
// Record stream from the TDC reader to the host FIFO/packetizer.
// master = record source (reader), slave = record sink.
interface tdc_record_reader_if;
   import tdc_reader_pkg::*;

   logic                 rec_valid;
   logic                 rec_ready;
   logic [EVENT_W-1:0]   rec_event;
   logic [CHANNEL_W-1:0] rec_channel;
   logic [DOUT_W-1:0]    rec_dout;
   logic [SAFF_W-1:0]    rec_saff;

   modport master (
      output rec_valid, rec_event, rec_channel, rec_dout, rec_saff,
      input  rec_ready
   );

   modport slave (
      input  rec_valid, rec_event, rec_channel, rec_dout, rec_saff,
      output rec_ready
   );

endinterface

// File: rtl/tdc_word_unpack.sv
// Combinational split of one channel's two RAM words into DOUT/SAFF fields,
// plus a flag for non-zero pad bits in word 0.
module tdc_word_unpack
   import tdc_reader_pkg::*;
(
   input  logic [15:0]       word0,
   input  logic [15:0]       word1,
   output logic [DOUT_W-1:0] dout,
   output logic [SAFF_W-1:0] saff,
   output logic              pad_nonzero
);

   assign dout        = word0[DOUT_MSB:DOUT_LSB];
   assign saff        = {word0[SAFF_HI_MSB:SAFF_HI_LSB], word1};
   assign pad_nonzero = |word0[PAD_MSB:PAD_LSB];

endmodule

// File: rtl/tdc_record_reader.sv
// Walks TDC event records in RAM (4 channels x 2 words per event) and hands
// decoded per-channel records to the host over valid/ready.
// Optional pad-bit checking: define TDC_READER_FORMAT_CHECK_EN.
module tdc_record_reader
   import tdc_reader_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int RAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        n_events,
   output logic              busy,
   output logic              done,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [15:0]       ram_rd_data,
   output logic              format_error,
   tdc_record_reader_if.master rec
);

   state_t               state, state_nxt;
   logic [1:0]           wait_cnt;
   logic                 wait_last;
   logic [ADDR_W-1:0]    ptr;
   logic [7:0]           n_lat;
   logic [EVENT_W-1:0]   evt;
   logic [CHANNEL_W-1:0] ch;
   logic [15:0]          word0_q, word1_q;
   logic                 pad_nonzero;
   logic                 accept, handshake, last_rec;

   assign accept    = (state == S_IDLE) && start;
   assign handshake = (state == S_PRESENT) && rec.rec_ready;
   assign last_rec  = (evt == n_lat - 8'd1) && (ch == CHANNEL_W'(N_CHANNELS - 1));
   assign wait_last = (wait_cnt == 2'(RAM_LATENCY - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (start) state_nxt = (n_events == 8'd0) ? S_DONE : S_RD_HI;
         S_RD_HI:   state_nxt = S_WAIT_HI;
         S_WAIT_HI: if (wait_last) state_nxt = S_RD_LO;
         S_RD_LO:   state_nxt = S_WAIT_LO;
         S_WAIT_LO: if (wait_last) state_nxt = S_PRESENT;
         S_PRESENT: if (rec.rec_ready) state_nxt = last_rec ? S_DONE : S_RD_HI;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Wait counter restarts on every read strobe and counts RAM latency cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == S_RD_HI || state == S_RD_LO) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT_HI || state == S_WAIT_LO) begin
         wait_cnt <= wait_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr     <= '0;
         n_lat   <= '0;
         evt     <= '0;
         ch      <= '0;
         word0_q <= '0;
         word1_q <= '0;
      end else begin
         if (accept) begin
            ptr   <= base_addr;
            n_lat <= n_events;
            evt   <= '0;
            ch    <= '0;
         end
         if (ram_rd_en) ptr <= ptr + 1'b1;
         if (state == S_WAIT_HI && wait_last) word0_q <= ram_rd_data;
         if (state == S_WAIT_LO && wait_last) word1_q <= ram_rd_data;
         if (handshake) begin
            ch <= ch + 1'b1;
            if (ch == CHANNEL_W'(N_CHANNELS - 1)) evt <= evt + 1'b1;
         end
      end
   end

   tdc_word_unpack u_unpack (
      .word0       (word0_q),
      .word1       (word1_q),
      .dout        (rec.rec_dout),
      .saff        (rec.rec_saff),
      .pad_nonzero (pad_nonzero)
   );

   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);
   assign ram_rd_en       = (state == S_RD_HI) || (state == S_RD_LO);
   assign ram_addr        = ptr;
   assign rec.rec_valid   = (state == S_PRESENT);
   assign rec.rec_event   = evt;
   assign rec.rec_channel = ch;

`ifdef TDC_READER_FORMAT_CHECK_EN
   logic fmt_err;

   // RD_LO directly follows the word0 capture, so the flag belongs to this run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 fmt_err <= 1'b0;
      else if (accept)                           fmt_err <= 1'b0;
      else if (state == S_RD_LO && pad_nonzero)  fmt_err <= 1'b1;
   end

   assign format_error = fmt_err;
`else
   logic unused_pad;

   assign unused_pad   = pad_nonzero;
   assign format_error = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_record_reader.sv
// Scoreboard bench for tdc_record_reader: expected records and RAM addresses
// are queued by the stimulus and consumed by a negedge monitor.
module tb_tdc_record_reader;
   import tdc_reader_pkg::*;

   typedef struct packed {
      logic [7:0]  ev;
      logic [1:0]  ch;
      logic [6:0]  dout;
      logic [20:0] saff;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [7:0]  n_events = '0;
   logic        busy, done, ram_rd_en, format_error;
   logic [9:0]  ram_addr;
   logic [15:0] ram_rd_data = '0;

   tdc_record_reader_if rif ();

   tdc_record_reader #(.ADDR_W(10), .RAM_LATENCY(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .n_events     (n_events),
      .busy         (busy),
      .done         (done),
      .ram_rd_en    (ram_rd_en),
      .ram_addr     (ram_addr),
      .ram_rd_data  (ram_rd_data),
      .format_error (format_error),
      .rec          (rif)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [1024];
   always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

   int tick = 0;
   int t0 = 0;
   always @(posedge clk) tick <= tick + 1;

   int total = 0;
   int bad = 0;
   rec_t       exp_q [$];
   logic [9:0] addr_q [$];

   logic [6:0]  pd [8] = '{7'h55, 7'h2A, 7'h7F, 7'h00, 7'h11, 7'h63, 7'h01, 7'h40};
   logic [20:0] ps [8] = '{21'h1FABCD, 21'h012345, 21'h000001, 21'h1FFFFF,
                           21'h0A5A5A, 21'h155555, 21'h100000, 21'h0F0F0F};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: every RAM read and every record handshake is checked in order.
   always @(negedge clk) begin
      if (!reset) begin
         if (ram_rd_en) begin
            if (addr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_read: got addr %0h required no read", ram_addr);
            end else begin
               check("ram_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
            end
         end
         if (rif.rec_valid && rif.rec_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_record: got ev %0d ch %0d required none",
                        rif.rec_event, rif.rec_channel);
            end else begin
               check("record",
                     64'({rif.rec_event, rif.rec_channel, rif.rec_dout, rif.rec_saff}),
                     64'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic load_events(input logic [9:0] base, input int nev, input int pat_off,
                              input logic [3:0] pad2);
      logic [9:0] a;
      a = base;
      for (int e = 0; e < nev; e++) begin
         for (int c = 0; c < 4; c++) begin
            int   k;
            rec_t r;
            k = (pat_off + e * 4 + c) % 8;
            mem[a] = {pd[k], (c == 2) ? pad2 : 4'h0, ps[k][20:16]};
            addr_q.push_back(a);
            a = a + 10'd1;
            mem[a] = ps[k][15:0];
            addr_q.push_back(a);
            a = a + 10'd1;
            r.ev = 8'(e); r.ch = 2'(c); r.dout = pd[k]; r.saff = ps[k];
            exp_q.push_back(r);
         end
      end
   endtask

   // Start edge becomes cycle-reference edge 0; later inputs are scrambled.
   task automatic do_start(input logic [9:0] b, input logic [7:0] n);
      @(posedge clk); #1;
      base_addr = b; n_events = n; start = 1'b1;
      t0 = tick + 1;
      @(posedge clk); #1;
      start = 1'b0; base_addr = ~b; n_events = 8'hFF;
   endtask

   task automatic wait_done(input string tag, output int done_cyc, output int first_valid,
                            output int n_rd);
      done_cyc = -1; first_valid = -1; n_rd = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (rif.rec_valid && first_valid < 0) first_valid = tick - t0 + 1;
         if (ram_rd_en) n_rd++;
         if (done) begin
            done_cyc = tick - t0 + 1;
            break;
         end
      end
      if (done_cyc < 0) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no done required done within 400 cycles", tag);
      end else begin
         @(negedge clk);
         check({tag, "_busy_after"}, 64'(busy), 64'd0);
         check({tag, "_done_pulse"}, 64'(done), 64'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   64'(busy), 0);
      check({tag, "_done"},   64'(done), 0);
      check({tag, "_rd_en"},  64'(ram_rd_en), 0);
      check({tag, "_addr"},   64'(ram_addr), 0);
      check({tag, "_valid"},  64'(rif.rec_valid), 0);
      check({tag, "_event"},  64'(rif.rec_event), 0);
      check({tag, "_chan"},   64'(rif.rec_channel), 0);
      check({tag, "_dout"},   64'(rif.rec_dout), 0);
      check({tag, "_saff"},   64'(rif.rec_saff), 0);
      check({tag, "_fmterr"}, 64'(format_error), 0);
   endtask

   initial begin
      int dc, fv, nr;
      rif.rec_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) reset = 1'b0;

      // Single event at 0x010, ready tied high.
      load_events(10'h010, 1, 0, 4'h0);
      do_start(10'h010, 8'd1);
      wait_done("single", dc, fv, nr);
      check("single_first_valid", 64'(fv), 64'd5);
      check("single_done_cycle", 64'(dc), 64'd21);
      check("single_n_reads", 64'(nr), 64'd8);
      check("single_q_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);

      // Backpressure in the first PRESENT, with an ignored start mid-run.
      rif.rec_ready = 1'b0;
      load_events(10'h040, 1, 2, 4'h0);
      do_start(10'h040, 8'd1);
      fv = -1;
      for (int i = 0; i < 50 && fv < 0; i++) begin
         @(negedge clk);
         if (rif.rec_valid) fv = tick - t0 + 1;
      end
      check("bp_first_valid", 64'(fv), 64'd5);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         check("bp_hold",
               64'({rif.rec_valid, ram_rd_en, busy, rif.rec_event, rif.rec_channel,
                    rif.rec_dout, rif.rec_saff}),
               64'({1'b1, 1'b0, 1'b1, 8'd0, 2'd0, 7'h7F, 21'h000001}));
         if (i == 3) begin
            @(posedge clk); #1;
            start = 1'b1; base_addr = 10'h300; n_events = 8'd5;
         end
         if (i == 4) begin
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      @(posedge clk); #1 rif.rec_ready = 1'b1;
      wait_done("bp", dc, fv, nr);
      check("bp_done_cycle", 64'(dc), 64'd31);
      check("bp_q_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);

      // Zero events.
      do_start(10'h155, 8'd0);
      wait_done("zero", dc, fv, nr);
      check("zero_done_cycle", 64'(dc), 64'd1);
      check("zero_no_valid", 64'(fv), 64'hFFFF_FFFF_FFFF_FFFF);
      check("zero_no_reads", 64'(nr), 64'd0);

      // Address wrap past 0x3FF.
      load_events(10'h3FC, 1, 5, 4'h0);
      do_start(10'h3FC, 8'd1);
      wait_done("wrap", dc, fv, nr);
      check("wrap_done_cycle", 64'(dc), 64'd21);
      check("wrap_q_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);

      // Reset in WAIT_LO of event 1 channel 2 (cycle 34), then a fresh run.
      load_events(10'h100, 2, 0, 4'h0);
      do_start(10'h100, 8'd2);
      while ((tick - t0 + 1) < 34) @(negedge clk);
      check("mid_state",
            64'({rif.rec_valid, ram_rd_en, rif.rec_event, rif.rec_channel}),
            64'({1'b0, 1'b0, 8'd1, 2'd2}));
      #1 reset = 1'b1;
      #1 check_reset_outputs("midreset");
      check("mid_recs_left", 64'(exp_q.size()), 64'd2);
      check("mid_reads_left", 64'(addr_q.size()), 64'd2);
      exp_q.delete();
      addr_q.delete();
      @(negedge clk) reset = 1'b0;
      load_events(10'h200, 1, 4, 4'h0);
      do_start(10'h200, 8'd1);
      wait_done("restart", dc, fv, nr);
      check("restart_first_valid", 64'(fv), 64'd5);
      check("restart_done_cycle", 64'(dc), 64'd21);
      check("restart_q_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);

      // Non-zero pad bits in channel 2 word 0; record content is unchanged.
      load_events(10'h080, 1, 1, 4'b0100);
      do_start(10'h080, 8'd1);
      wait_done("fmt", dc, fv, nr);
      check("fmt_q_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
`ifdef TDC_READER_FORMAT_CHECK_EN
      check("fmt_err_sticky", 64'(format_error), 64'd1);
      do_start(10'h000, 8'd0);
      @(negedge clk);
      check("fmt_err_cleared", 64'(format_error), 64'd0);
      wait_done("fmt_clear", dc, fv, nr);
`else
      check("fmt_err_disabled", 64'(format_error), 64'd0);
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
